// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the CPU in reset until the whole image has been written.
module imem_loader #(
   parameter int DEPTH = 1024,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        restart,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset_hold,
   output logic        done,
   output logic        error
);

   // word_idx must be able to reach DEPTH itself when the image fills memory
   localparam int          WI_W    = $clog2(DEPTH) + 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [WI_W-1:0]   word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       asm_q, asm_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [63:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              xfer;
   logic [15:0]       n_hdr;
   logic [WI_W-1:0]   word_idx_inc;

   assign xfer         = in_valid & in_ready_q;
   assign n_hdr        = {in_data, n_q[7:0]};
   assign word_idx_inc = word_idx_q + WI_W'(1);

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      asm_d       = asm_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         HDR0: if (xfer) begin
            n_d[7:0] = in_data;
            state_d  = HDR1;
         end
         HDR1: if (xfer) begin
            n_d = CNT_W'(n_hdr);
            if (n_hdr == 16'd0)              state_d = DONE;
            else if (32'(n_hdr) > DEPTH_U)   state_d = ERR;
            else                             state_d = DATA;
         end
         DATA: if (xfer) begin
            asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
               // the 4th byte goes straight into the write data, not via asm_q
               mem_wdata_d = {in_data, asm_q[23:0]};
               mem_addr_d  = {62'(word_idx_q), 2'b00};
               state_d     = WRITE;
            end
         end
         WRITE: begin
            word_idx_d = word_idx_inc;
            state_d    = (32'(word_idx_inc) == 32'(n_q)) ? DONE : DATA;
         end
         DONE, ERR: if (restart) begin
            state_d    = HDR0;
            n_d        = '0;
            word_idx_d = '0;
            byte_idx_d = '0;
         end
         default: state_d = HDR0;
      endcase

      // outputs are a pure decode of the next state so they come straight off flops
      in_ready_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA);
      mem_we_d   = (state_d == WRITE);
      done_d     = (state_d == DONE);
      error_d    = (state_d == ERR);
      hold_d     = (state_d != DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= HDR0;
         n_q         <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         asm_q       <= '0;
         in_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hold_q      <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         asm_q       <= asm_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hold_q      <= hold_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign cpu_reset_hold = hold_q;
   assign done           = done_q;
   assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: per-cycle vector table plus hand sequences for
// randomised handshake gaps, full-depth fill and mid-load reset.
module tb_imem_loader;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        restart = 1'b0;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_reset_hold;
   logic        done;
   logic        error;

   int checks = 0;
   int failures = 0;

   logic [63:0] cap_addr[$];
   logic [31:0] cap_data[$];

   imem_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .restart(restart), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_reset_hold(cpu_reset_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         cap_addr.push_back(mem_addr);
         cap_data.push_back(mem_wdata);
      end
   end

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rs;
      logic        r;
      logic        we;
      logic [63:0] a;
      logic [31:0] wd;
      logic        dn;
      logic        er;
      logic        h;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic [7:0] d, input logic rs,
                      input logic r, input logic we, input logic [63:0] a,
                      input logic [31:0] wd, input logic dn, input logic er,
                      input logic h);
      vec_t t;
      t.v = v; t.d = d; t.rs = rs; t.r = r; t.we = we; t.a = a;
      t.wd = wd; t.dn = dn; t.er = er; t.h = h;
      vecs.push_back(t);
   endtask

   function automatic logic [127:0] pack(input logic r, input logic we,
                                         input logic [63:0] a, input logic [31:0] wd,
                                         input logic dn, input logic er, input logic h);
      return {27'b0, r, we, a, wd, dn, er, h};
   endfunction

   function automatic logic [127:0] outs_now();
      return pack(in_ready, mem_we, mem_addr, mem_wdata, done, error, cpu_reset_hold);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  n;
      logic acc;
      n = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      while (!acc && n < 20) begin
         acc = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_byte_timeout byte=%0h got=not_accepted want=accepted", b);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         tick();
      end
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk(nm, 128'(done), 128'(1));
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   initial begin
      logic [7:0] img1 [10];
      logic [7:0] img2 [6];
      int bad;

      #1 reset = 1'b1;
      #1 chk("async_reset_values", outs_now(), pack(1, 0, 0, 0, 0, 0, 1));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_values_held", outs_now(), pack(1, 0, 0, 0, 0, 0, 1));

      // image 1: two words, then done
      add(1, 8'h02, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 8'h21, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 8'h04, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 8'h91, 0, 0, 1, 0, 32'h91000421, 0, 0, 1);
      add(0, 8'h00, 0, 1, 0, 0, 32'h91000421, 0, 0, 1);
      add(1, 8'h00, 0, 1, 0, 0, 32'h91000421, 0, 0, 1);
      add(1, 8'h00, 0, 1, 0, 0, 32'h91000421, 0, 0, 1);
      add(1, 8'h00, 0, 1, 0, 0, 32'h91000421, 0, 0, 1);
      add(1, 8'hB4, 0, 0, 1, 4, 32'hB4000000, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 4, 32'hB4000000, 1, 0, 0);
      add(1, 8'hFF, 0, 0, 0, 4, 32'hB4000000, 1, 0, 0);
      // restart, then empty image N=0
      add(0, 8'h00, 1, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h00, 0, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h00, 0, 0, 0, 4, 32'hB4000000, 1, 0, 0);
      add(1, 8'h55, 0, 0, 0, 4, 32'hB4000000, 1, 0, 0);
      // restart, then N=DEPTH+1 -> error, extra bytes ignored
      add(0, 8'h00, 1, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h01, 0, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h04, 0, 0, 0, 4, 32'hB4000000, 0, 1, 1);
      add(1, 8'hAA, 0, 0, 0, 4, 32'hB4000000, 0, 1, 1);
      add(1, 8'hBB, 0, 0, 0, 4, 32'hB4000000, 0, 1, 1);
      add(0, 8'h00, 1, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      // one-word image with a restart pulse mid-load that must be ignored
      add(1, 8'h01, 0, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h00, 0, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h78, 0, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h56, 1, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h34, 0, 1, 0, 4, 32'hB4000000, 0, 0, 1);
      add(1, 8'h12, 0, 0, 1, 0, 32'h12345678, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0, 32'h12345678, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].v;
         in_data  = vecs[i].d;
         restart  = vecs[i].rs;
         tick();
         restart  = 1'b0;
         chk($sformatf("vec%0d", i), outs_now(),
             pack(vecs[i].r, vecs[i].we, vecs[i].a, vecs[i].wd,
                  vecs[i].dn, vecs[i].er, vecs[i].h));
      end
      in_valid = 1'b0;

      // full-depth image: N == DEPTH is legal and fills memory
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cap_addr.delete();
      cap_data.delete();
      send_byte(8'h00);
      send_byte(8'h04);
      chk("fill_hdr_not_error", 128'({error, in_ready}), 128'(2'b01));
      for (int w = 0; w < DEPTH; w++) begin
         logic [31:0] word;
         word = 32'hA5000000 | 32'(w);
         for (int b = 0; b < 4; b++) send_byte(word[b*8 +: 8]);
      end
      wait_done("fill_done");
      chk("fill_count", 128'(cap_addr.size()), 128'(DEPTH));
      bad = 0;
      for (int w = 0; w < cap_addr.size(); w++) begin
         if (cap_addr[w] !== 64'(w * 4) || cap_data[w] !== (32'hA5000000 | 32'(w))) bad++;
      end
      chk("fill_contents_bad", 128'(bad), 128'(0));
      if (cap_addr.size() > 0)
         chk("fill_last_addr", 128'(cap_addr[cap_addr.size()-1]), 128'(64'hFFC));

      // image 1 with random idle gaps
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cap_addr.delete();
      cap_data.delete();
      img1 = '{8'h02, 8'h00, 8'h21, 8'h04, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00, 8'hB4};
      for (int i = 0; i < 10; i++) begin
         gap(int'($urandom_range(0, 5)));
         send_byte(img1[i]);
      end
      wait_done("gap_done");
      chk("gap_count", 128'(cap_addr.size()), 128'(2));
      if (cap_addr.size() == 2) begin
         chk("gap_w0", {cap_addr[0], cap_data[0]}, {64'h0, 32'h91000421});
         chk("gap_w1", {cap_addr[1], cap_data[1]}, {64'h4, 32'hB4000000});
      end
      chk("gap_hold_released", 128'(cpu_reset_hold), 128'(0));

      // reset in the middle of word 0
      pulse_restart();
      cap_addr.delete();
      cap_data.delete();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b1;
      #1 chk("midload_reset_values", outs_now(), pack(1, 0, 0, 0, 0, 0, 1));
      tick();
      reset = 1'b0;
      chk("midload_no_write", 128'(cap_addr.size()), 128'(0));
      img2 = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 6; i++) send_byte(img2[i]);
      wait_done("reload_done");
      chk("reload_count", 128'(cap_addr.size()), 128'(1));
      if (cap_addr.size() == 1)
         chk("reload_w0", {cap_addr[0], cap_data[0]}, {64'h0, 32'hDEADBEEF});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
